pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline-stage buffer: the generalised successor to the fixed single-entry IF/ID latch. Holds up to DEPTH in-order entries (payload, PC, exception sideband) between two pipeline stages with a valid/ready handshake, a flush that converts all contents into bubbles, and an exception fence that stops intake behind a faulting entry. It is instantiated between fetch and decode, and is reusable between any two stages.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_buf_mem.sv | 40 ++++
 rtl/pipe_stage_buf.sv | 115 +++++++++++
 tb/tb_pipe_stage_buf.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------
// pipe_pkg : shared types and helpers for the pipe_stage_buf slice
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam logic [31:0] BUBBLE_INSN = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        exc;
    logic [31:0] exc_addr;
  } pipe_entry_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_buf_mem.sv
// ---------------------------------------------------------------
// pipe_buf_mem : DEPTH x ENTRY_W register array, 1 write, 1 async read
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pipe_buf_mem #(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 64,
  parameter int PTR_W   = 1
) (
  input  logic               clock,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  if (DEPTH > 1) begin : g_array
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
  end else begin : g_single
    logic [ENTRY_W-1:0] mem;

    always_ff @(posedge clock) begin
      if (we) mem <= wdata;
    end

    assign rdata = mem;
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------
// pipe_stage_buf : elastic in-order stage buffer with flush and exception
// fence. Exception sideband and fence exist only with `define PIPE_EXC_EN.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               ADDR_W = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_INSN)
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [ADDR_W-1:0]           in_pc,
`ifdef PIPE_EXC_EN
  input  logic                        in_exc,
  input  logic [ADDR_W-1:0]           in_exc_addr,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [ADDR_W-1:0]           out_pc,
`ifdef PIPE_EXC_EN
  output logic                        out_exc,
  output logic [ADDR_W-1:0]           out_exc_addr,
`endif
  output logic [occ_width(DEPTH)-1:0] count
);

  localparam int CNT_W = occ_width(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PIPE_EXC_EN
  localparam int ENTRY_W = WIDTH + ADDR_W + 1 + ADDR_W;
`else
  localparam int ENTRY_W = WIDTH + ADDR_W;
`endif

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               fence;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // in_ready is purely registered state, so a pop never frees a slot for the same edge
  assign out_valid = (count != '0);
  assign in_ready  = (count < CNT_W'(DEPTH)) && !fence;
  assign push      = in_valid && in_ready && !flush && !rst;
  assign pop       = out_valid && out_ready && !flush && !rst;

`ifdef PIPE_EXC_EN
  assign wr_entry     = {in_data, in_pc, in_exc, in_exc_addr};
  assign out_exc      = out_valid && rd_entry[ADDR_W];
  assign out_exc_addr = out_valid ? rd_entry[ADDR_W-1:0] : '0;

  // The exception entry is always the youngest, so its pop is what lifts the fence
  always_ff @(posedge clock) begin
    if (rst || flush)             fence <= 1'b0;
    else if (pop && out_exc)      fence <= 1'b0;
    else if (push && in_exc)      fence <= 1'b1;
  end
`else
  assign wr_entry = {in_data, in_pc};
  assign fence    = 1'b0;
`endif

  assign out_data = out_valid ? rd_entry[ENTRY_W-1 -: WIDTH] : BUBBLE;
  assign out_pc   = out_valid ? rd_entry[ENTRY_W-WIDTH-1 -: ADDR_W] : '0;

  always_ff @(posedge clock) begin
    if (rst || flush)        count <= '0;
    else if (push && !pop)   count <= count + CNT_W'(1);
    else if (pop && !push)   count <= count - CNT_W'(1);
  end

  if (DEPTH > 1) begin : g_ptr
    always_ff @(posedge clock) begin
      if (rst || flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end else begin : g_no_ptr
    assign wr_ptr = '0;
    assign rd_ptr = '0;
  end

  pipe_buf_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .PTR_W   (PTR_W)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------
// tb_pipe_stage_buf : queue-scoreboard bench for pipe_stage_buf (DEPTH=2)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] BUBBLE_V = 32'h0;

  logic        clock;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_pc;
  logic [1:0]  count;
`ifdef PIPE_EXC_EN
  logic        in_exc;
  logic [31:0] in_exc_addr;
  logic        out_exc;
  logic [31:0] out_exc_addr;
`endif

  int vectors     = 0;
  int miscompares = 0;

  pipe_entry_t exp_q[$];
  logic        fence_m = 1'b0;

  pipe_stage_buf #(
    .WIDTH  (32),
    .ADDR_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_pc        (in_pc),
`ifdef PIPE_EXC_EN
    .in_exc       (in_exc),
    .in_exc_addr  (in_exc_addr),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_pc       (out_pc),
`ifdef PIPE_EXC_EN
    .out_exc      (out_exc),
    .out_exc_addr (out_exc_addr),
`endif
    .count        (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input logic [31:0] d);
    return 32'h1000 + {d[29:0], 2'b00};
  endfunction

  // Called at the falling edge: drive inputs, check outputs, advance model over one rising edge
  task automatic cycle(input logic r, input logic f, input logic v, input logic [31:0] d,
                       input logic e, input logic [31:0] ea, input logic ordy);
    pipe_entry_t ent;
    pipe_entry_t head;
    logic        rdy_m;
    logic        push_m;
    logic        pop_m;
    int          sz;
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_data   = d;
    in_pc     = pc_of(d);
    out_ready = ordy;
`ifdef PIPE_EXC_EN
    in_exc      = e;
    in_exc_addr = ea;
`endif
    sz    = exp_q.size();
    rdy_m = (sz < DEPTH) && !fence_m;
    head  = (sz != 0) ? exp_q[0] : '0;
    check("count",     64'(count),     64'(sz));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    check("in_ready",  64'(in_ready),  64'(rdy_m));
    check("out_data",  64'(out_data),  64'((sz != 0) ? head.data : BUBBLE_V));
    check("out_pc",    64'(out_pc),    64'((sz != 0) ? head.pc : 32'h0));
`ifdef PIPE_EXC_EN
    check("out_exc",      64'(out_exc),      64'((sz != 0) && head.exc));
    check("out_exc_addr", 64'(out_exc_addr), 64'((sz != 0) ? head.exc_addr : 32'h0));
`endif
    push_m = v && rdy_m && !f && !r;
    pop_m  = (sz != 0) && ordy && !f && !r;
    ent.data     = d;
    ent.pc       = pc_of(d);
`ifdef PIPE_EXC_EN
    ent.exc      = e;
    ent.exc_addr = ea;
`else
    ent.exc      = 1'b0;
    ent.exc_addr = 32'h0;
`endif
    @(posedge clock);
    if (r || f) begin
      exp_q.delete();
      fence_m = 1'b0;
    end else begin
      if (pop_m) begin
        head = exp_q.pop_front();
        if (head.exc) fence_m = 1'b0;
      end
      if (push_m) begin
        exp_q.push_back(ent);
        if (ent.exc) fence_m = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
`ifdef PIPE_EXC_EN
    in_exc      = 1'b0;
    in_exc_addr = '0;
`endif
    @(negedge clock);

    // fill, overfill attempt, drain
    cycle(0, 0, 1, 32'hA1, 0, 0, 0);
    cycle(0, 0, 1, 32'hA2, 0, 0, 0);
    cycle(0, 0, 1, 32'hA3, 0, 0, 0);
    cycle(0, 0, 0, 32'h0,  0, 0, 1);
    cycle(0, 0, 0, 32'h0,  0, 0, 1);
    cycle(0, 0, 0, 32'h0,  0, 0, 0);

    // streaming with wrap
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 32'h10 + 32'(i), 0, 0, 1);
    for (int i = 0; i < 3; i++)  cycle(0, 0, 0, 32'h0, 0, 0, 1);

    // flush with a coincident push
    cycle(0, 0, 1, 32'h31, 0, 0, 0);
    cycle(0, 0, 1, 32'h32, 0, 0, 0);
    cycle(0, 1, 1, 32'h33, 0, 0, 1);
    cycle(0, 0, 0, 32'h0,  0, 0, 1);
    cycle(0, 0, 0, 32'h0,  0, 0, 1);

`ifdef PIPE_EXC_EN
    // exception fence
    cycle(0, 0, 1, 32'h40, 0, 0, 0);
    cycle(0, 0, 1, 32'h41, 1, 32'h1000, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h42, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h42, 0, 0, 1);
    cycle(0, 0, 0, 32'h0, 0, 0, 1);
`endif

    // rst + flush mid-stream (fence set when the sideband exists)
    cycle(0, 0, 1, 32'h43, 1, 32'h2000, 0);
    cycle(0, 0, 1, 32'h44, 0, 0, 0);
    cycle(1, 1, 1, 32'h45, 0, 0, 1);
    cycle(0, 0, 1, 32'h50, 0, 0, 0);
    cycle(0, 0, 0, 32'h0,  0, 0, 1);
    cycle(0, 0, 0, 32'h0,  0, 0, 1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0), 32'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
